// File: rtl/axis_pkt_pkg.sv
// Shared types and constants for the AXI-Stream packet sink.
// Holds the stall FSM state enum, the pkt_len width and LFSR helpers.
package axis_pkt_pkg;

    typedef enum logic {
        ACCEPT = 1'b0,
        HOLD   = 1'b1
    } stall_state_t;

    localparam int PKT_LEN_W = 16;

    function automatic logic [PKT_LEN_W-1:0] sat_inc(
        input logic [PKT_LEN_W-1:0] v
    );
        return (v == {PKT_LEN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

`ifdef AXIS_PKT_SINK_RAND_STALL_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11 (maximal length)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
`endif

endpackage

// File: rtl/axis_pkt_fifo.sv
// First-word fall-through beat FIFO for the packet sink.
// Ports: clk, rst (sync high), wr_en/wr_data push, rd_en pop,
// rd_data shows the head, full flags no free slot.
module axis_pkt_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB separates full (MSBs differ) from empty.
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot a full push needs.
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axis_pkt_sink.sv
// Store-and-forward AXI-Stream packet sink with optional backpressure.
// Ports: clk, rst (sync high); s_axis_* slave input; rd_* FWFT pop
// port; pkt_done/pkt_len per-packet report; pkt_count packets held;
// err_oversize sticky. Macro AXIS_PKT_SINK_RAND_STALL_EN selects an
// LFSR-driven 0..7 cycle stall instead of the fixed STALL count.
module axis_pkt_sink
    import axis_pkt_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int DEPTH       = 64,
    parameter int STALL       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   rd_en,
    output logic [TDATA_WIDTH-1:0] rd_data,
    output logic                   rd_last,
    output logic                   rd_valid,
    output logic                   pkt_done,
    output logic [PKT_LEN_W-1:0]   pkt_len,
    output logic [$clog2(DEPTH):0] pkt_count,
    output logic                   err_oversize
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE = 1;

    stall_state_t state;
    stall_state_t state_nxt;

    logic [15:0]            hold_cnt;
    logic [15:0]            hold_cnt_nxt;
    logic [15:0]            hold_len;
    logic [15:0]            stall_len;
    logic [PKT_LEN_W-1:0]   beat_cnt;
    logic [TDATA_WIDTH:0]   head;
    logic                   full;
    logic                   accept;
    logic                   pop;
    logic                   acc_last;
    logic                   pop_last;

    assign s_axis_tready = !rst && (state == ACCEPT) && !full;
    // A full FIFO with no complete packet releases the partial one.
    assign rd_valid = !rst && ((pkt_count != '0) || full);

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign pop      = rd_en && rd_valid;
    assign acc_last = accept && s_axis_tlast;
    assign pop_last = pop && rd_last;

    assign rd_data = head[TDATA_WIDTH:1];
    assign rd_last = head[0];

    axis_pkt_fifo #(
        .WIDTH (TDATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data ({s_axis_tdata, s_axis_tlast}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full)
    );

`ifdef AXIS_PKT_SINK_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else if (accept) lfsr <= lfsr_next(lfsr);
    end

    assign stall_len = {13'd0, lfsr[2:0]};
`else
    assign stall_len = 16'(STALL);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCEPT;
            hold_cnt <= '0;
            hold_len <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            if (accept) hold_len <= stall_len;
        end
    end

    // HOLD lasts exactly hold_len cycles.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        unique case (state)
            ACCEPT: begin
                if (accept && (stall_len != '0)) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            HOLD: begin
                if (hold_cnt == hold_len - 16'd1) begin
                    state_nxt    = ACCEPT;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else begin
            unique case ({acc_last, pop_last})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
        end else begin
            pkt_done <= acc_last;
            if (acc_last) begin
                pkt_len  <= sat_inc(beat_cnt);
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= sat_inc(beat_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_oversize <= 1'b0;
        else if (full && (pkt_count == '0)) err_oversize <= 1'b1;
    end

endmodule
